// File: rtl/actmem_ext_burst_arbiter.sv
// External burst arbiter in front of the activation memory: round-robin grant, one word per cycle.
// Optional perf counters: define ACTMEM_ARB_PERF_CNT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | no burst; internal side owns memory, grants made
// S_BURST_RD | issuing read beats for the granted port
// S_BURST_WR | accepting write beats for the granted port
// S_DRAIN    | last read issued, waiting for its rvalid
module actmem_ext_burst_arbiter #(
  parameter int NUM_EXT_PORTS = 2,
  parameter int NUMBANKS      = 24,
  parameter int BANKDEPTH     = 2048,
  parameter int NUMBANKSETS   = 3,
  parameter int WORDWIDTH     = 80,
  parameter int MAX_BURST     = 16,
  parameter int STARVE_LIMIT  = 8,
  localparam int AW  = $clog2(NUMBANKS * BANKDEPTH),
  localparam int BSW = (NUMBANKSETS > 1) ? $clog2(NUMBANKSETS) : 1,
  localparam int LW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int PW  = (NUM_EXT_PORTS > 1) ? $clog2(NUM_EXT_PORTS) : 1,
  localparam int BKW = $clog2(NUMBANKS),
  localparam int RW  = $clog2(BANKDEPTH),
  localparam int SW  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_EXT_PORTS-1:0]     ext_req_i,
  input  logic [NUM_EXT_PORTS-1:0]     ext_we_i,
  input  logic [NUM_EXT_PORTS*AW-1:0]  ext_addr_i,
  input  logic [NUM_EXT_PORTS*BSW-1:0] ext_bank_set_i,
  input  logic [NUM_EXT_PORTS*LW-1:0]  ext_len_i,
  output logic [NUM_EXT_PORTS-1:0]     ext_gnt_o,
  input  logic [WORDWIDTH-1:0]         ext_wdata_i,
  input  logic                         ext_wvalid_i,
  output logic                         ext_wready_o,
  output logic [WORDWIDTH-1:0]         ext_rdata_o,
  output logic                         ext_rvalid_o,
  output logic [PW-1:0]                ext_rid_o,
  output logic                         ext_err_o,
  input  logic                         int_req_i,
  output logic                         int_stall_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [BKW-1:0]               mem_bank_o,
  output logic [RW-1:0]                mem_row_o,
  output logic [BSW-1:0]               mem_bank_set_o,
  output logic [WORDWIDTH-1:0]         mem_wdata_o,
  input  logic [WORDWIDTH-1:0]         mem_rdata_i
`ifdef ACTMEM_ARB_PERF_CNT_EN
  ,
  input  logic                         perf_clr_i,
  output logic [31:0]                  perf_ext_beats_o,
  output logic [31:0]                  perf_int_stall_o,
  output logic [15:0]                  perf_yield_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BURST_RD, S_BURST_WR, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            rr_q, rr_d, port_q, port_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic [BKW-1:0]           bank_q, bank_d;
  logic [RW-1:0]            row_q, row_d;
  logic [BSW-1:0]           set_q, set_d;
  logic [LW-1:0]            left_q, left_d;
  logic                     rvalid_q, rvalid_d, err_q, err_d;
  logic [NUM_EXT_PORTS-1:0] gnt_q, gnt_d;

  logic          burst_act, yield, stall, beat, at_top, found;
  logic [PW-1:0] cand, sel;
  logic [AW-1:0] addr_sel;

  assign burst_act = (state_q == S_BURST_RD) || (state_q == S_BURST_WR);
  // A yield hands exactly one slot to the internal side; it also holds off the ext beat.
  assign yield     = burst_act && (starve_q == SW'(STARVE_LIMIT));
  assign stall     = int_req_i && burst_act && !yield;
  assign beat      = !yield && ((state_q == S_BURST_RD) ||
                                ((state_q == S_BURST_WR) && ext_wvalid_i));
  assign at_top    = (bank_q == BKW'(NUMBANKS - 1)) && (row_q == RW'(BANKDEPTH - 1));

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    port_d   = port_q;
    bank_d   = bank_q;
    row_d    = row_q;
    set_d    = set_q;
    left_d   = left_q;
    gnt_d    = '0;
    err_d    = 1'b0;
    rvalid_d = 1'b0;
    starve_d = stall ? starve_q + SW'(1) : '0;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    addr_sel = '0;

    // Descending scan so the port closest to the pointer is the last one written.
    for (int k = NUM_EXT_PORTS - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_q) + k) % NUM_EXT_PORTS);
      if (ext_req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    addr_sel = AW'(ext_addr_i >> (int'(sel) * AW));

    case (state_q)
      S_IDLE: begin
        if (found && !int_req_i) begin
          gnt_d[sel] = 1'b1;
          port_d     = sel;
          rr_d       = PW'((int'(sel) + 1) % NUM_EXT_PORTS);
          bank_d     = BKW'(addr_sel % AW'(NUMBANKS));
          row_d      = RW'(addr_sel / AW'(NUMBANKS));
          set_d      = BSW'(ext_bank_set_i >> (int'(sel) * BSW));
          left_d     = LW'(ext_len_i >> (int'(sel) * LW));
          state_d    = ext_we_i[sel] ? S_BURST_WR : S_BURST_RD;
        end
      end
      S_BURST_RD, S_BURST_WR: begin
        if (beat) begin
          rvalid_d = (state_q == S_BURST_RD);
          if ((left_q == '0) || at_top) begin
            err_d   = (left_q != '0);
            state_d = (state_q == S_BURST_RD) ? S_DRAIN : S_IDLE;
          end else begin
            left_d = left_q - LW'(1);
            if (bank_q == BKW'(NUMBANKS - 1)) begin
              bank_d = '0;
              row_d  = row_q + RW'(1);
            end else begin
              bank_d = bank_q + BKW'(1);
            end
          end
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      port_q   <= '0;
      starve_q <= '0;
      bank_q   <= '0;
      row_q    <= '0;
      set_q    <= '0;
      left_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      port_q   <= port_d;
      starve_q <= starve_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      set_q    <= set_d;
      left_q   <= left_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      gnt_q    <= gnt_d;
    end
  end

  assign ext_gnt_o      = gnt_q;
  assign ext_wready_o   = (state_q == S_BURST_WR) && !yield;
  assign ext_rvalid_o   = rvalid_q;
  assign ext_rdata_o    = rvalid_q ? mem_rdata_i : '0;
  assign ext_rid_o      = port_q;
  assign ext_err_o      = err_q;
  assign int_stall_o    = stall;
  assign mem_req_o      = beat;
  assign mem_we_o       = beat && (state_q == S_BURST_WR);
  assign mem_bank_o     = beat ? bank_q : '0;
  assign mem_row_o      = beat ? row_q : '0;
  assign mem_bank_set_o = beat ? set_q : '0;
  assign mem_wdata_o    = mem_we_o ? ext_wdata_i : '0;

`ifdef ACTMEM_ARB_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_beats_d, perf_stall_q, perf_stall_d;
  logic [15:0] perf_yield_q, perf_yield_d;

  always_comb begin
    perf_beats_d = perf_beats_q;
    perf_stall_d = perf_stall_q;
    perf_yield_d = perf_yield_q;
    if (perf_clr_i) begin
      perf_beats_d = '0;
      perf_stall_d = '0;
      perf_yield_d = '0;
    end else begin
      if (beat && (perf_beats_q != '1)) perf_beats_d = perf_beats_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
      if (yield && (perf_yield_q != '1)) perf_yield_d = perf_yield_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
      perf_yield_q <= '0;
    end else begin
      perf_beats_q <= perf_beats_d;
      perf_stall_q <= perf_stall_d;
      perf_yield_q <= perf_yield_d;
    end
  end

  assign perf_ext_beats_o = perf_beats_q;
  assign perf_int_stall_o = perf_stall_q;
  assign perf_yield_o     = perf_yield_q;
`endif

endmodule

// File: tb/tb_actmem_ext_burst_arbiter.sv
// Directed bench for actmem_ext_burst_arbiter: scoreboard of expected issues and read returns.
module tb_actmem_ext_burst_arbiter;
  localparam int AW = 16, BSW = 2, LW = 4, PW = 1, BKW = 5, RW = 11, W = 80;
  localparam int NB = 24, BD = 2048;

  logic          clk = 1'b0, rst = 1'b1;
  logic [1:0]    ext_req_i = '0, ext_we_i = '0, ext_gnt_o;
  logic [AW-1:0] addr_a [2];
  logic [BSW-1:0] set_a [2];
  logic [LW-1:0] len_a [2];
  logic [W-1:0]  ext_wdata_i = '0, ext_rdata_o, mem_wdata_o, mem_rdata_i = '0;
  logic          ext_wvalid_i = 1'b0, ext_wready_o, ext_rvalid_o, ext_err_o;
  logic [PW-1:0] ext_rid_o;
  logic          int_req_i = 1'b0, int_stall_o, mem_req_o, mem_we_o;
  logic [BKW-1:0] mem_bank_o;
  logic [RW-1:0] mem_row_o;
  logic [BSW-1:0] mem_bank_set_o;

  actmem_ext_burst_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i),
    .ext_addr_i({addr_a[1], addr_a[0]}), .ext_bank_set_i({set_a[1], set_a[0]}),
    .ext_len_i({len_a[1], len_a[0]}), .ext_gnt_o(ext_gnt_o),
    .ext_wdata_i(ext_wdata_i), .ext_wvalid_i(ext_wvalid_i), .ext_wready_o(ext_wready_o),
    .ext_rdata_o(ext_rdata_o), .ext_rvalid_o(ext_rvalid_o), .ext_rid_o(ext_rid_o),
    .ext_err_o(ext_err_o), .int_req_i(int_req_i), .int_stall_o(int_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_bank_o(mem_bank_o),
    .mem_row_o(mem_row_o), .mem_bank_set_o(mem_bank_set_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           we;
    logic [BKW-1:0] bank;
    logic [RW-1:0]  row;
    logic [BSW-1:0] set;
    logic [W-1:0]   wdata;
    logic           port;
  } iss_t;
  typedef struct {
    logic [W-1:0] data;
    logic         port;
  } rd_t;

  iss_t iss_q[$];
  rd_t  rd_q[$];
  int   n_assert = 0, n_fail = 0;
  int   n_issue = 0, n_rvalid = 0, n_stall = 0, n_err = 0, n_gnt0 = 0, n_gnt1 = 0;
  int   exp_err = 0;
  logic mon_en = 1'b0, prev_rd = 1'b0;

  function automatic logic [W-1:0] pat(input logic [BKW-1:0] b, input logic [RW-1:0] r,
                                       input logic [BSW-1:0] s);
    logic [W-1:0] v;
    v = 80'h5A5A_0000_0000_0000_0000;
    v[4:0]   = b;
    v[15:5]  = r;
    v[17:16] = s;
    return v;
  endfunction

  function automatic logic [W-1:0] wpat(input int k);
    logic [W-1:0] v;
    v = 80'hBEEF_1234_0000_0000_0000;
    v[7:0] = 8'(k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory model: read data appears the cycle after the read request
  always @(posedge clk)
    if (mem_req_o && !mem_we_o) mem_rdata_i <= pat(mem_bank_o, mem_row_o, mem_bank_set_o);

  always @(negedge clk) begin : mon
    iss_t e;
    rd_t  r;
    if (rst || !mon_en) prev_rd = 1'b0;
    else begin
      check("rvalid_timing", 128'(ext_rvalid_o), 128'(prev_rd));
      if (ext_rvalid_o) begin
        n_rvalid++;
        if (rd_q.size() == 0) check("unexp_rvalid", 128'(1), 128'(0));
        else begin
          r = rd_q.pop_front();
          check("rdata", 128'(ext_rdata_o), 128'(r.data));
          check("rid", 128'(ext_rid_o), 128'(r.port));
        end
      end
      prev_rd = 1'b0;
      if (mem_req_o) begin
        n_issue++;
        if (iss_q.size() == 0) check("unexp_issue", 128'(1), 128'(0));
        else begin
          e = iss_q.pop_front();
          check("issue_we", 128'(mem_we_o), 128'(e.we));
          check("issue_bank", 128'(mem_bank_o), 128'(e.bank));
          check("issue_row", 128'(mem_row_o), 128'(e.row));
          check("issue_set", 128'(mem_bank_set_o), 128'(e.set));
          if (e.we) check("issue_wdata", 128'(mem_wdata_o), 128'(e.wdata));
          else begin
            r.data = pat(e.bank, e.row, e.set);
            r.port = e.port;
            rd_q.push_back(r);
            prev_rd = 1'b1;
          end
        end
      end
      if (int_stall_o) n_stall++;
      if (ext_err_o) n_err++;
      if (ext_gnt_o[0]) n_gnt0++;
      if (ext_gnt_o[1]) n_gnt1++;
    end
  end

  // reference address walk: bank-major increment, stop at top of memory
  task automatic push_burst(input logic p, input logic we, input int addr, input int set,
                            input int len, output int n);
    iss_t e;
    int bank, row;
    bank = addr % NB;
    row  = addr / NB;
    n    = 0;
    for (int b = 0; b <= len; b++) begin
      e.we = we; e.bank = BKW'(bank); e.row = RW'(row); e.set = BSW'(set);
      e.wdata = wpat(b); e.port = p;
      iss_q.push_back(e);
      n++;
      if (b == len) break;
      if (bank == NB - 1 && row == BD - 1) begin
        exp_err++;
        break;
      end
      if (bank == NB - 1) begin bank = 0; row++; end
      else bank++;
    end
  endtask

  task automatic set_req(input logic p, input logic we, input int addr, input int set, input int len);
    addr_a[p] = AW'(addr);
    set_a[p]  = BSW'(set);
    len_a[p]  = LW'(len);
    ext_we_i[p]  = we;
    ext_req_i[p] = 1'b1;
  endtask

  task automatic wait_gnt(input logic p, input string tag);
    logic [1:0] exp_g;
    exp_g = 2'b00;
    exp_g[p] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ext_gnt_o != 2'b00) break;
    end
    check(tag, 128'(ext_gnt_o), 128'(exp_g));
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((iss_q.size() != 0 || rd_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 128'(iss_q.size() + rd_q.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic p, input int addr, input int set, input int len);
    int n, k, t;
    push_burst(p, 1'b1, addr, set, len, n);
    ext_wvalid_i = 1'b1;
    ext_wdata_i  = wpat(0);
    @(negedge clk);
    check("wr_wready_idle", 128'(ext_wready_o), 128'(0));
    set_req(p, 1'b1, addr, set, len);
    wait_gnt(p, "wr_gnt");
    ext_req_i[p] = 1'b0;
    k = 0; t = 0;
    while (k < n && t < 100) begin
      if (ext_wready_o) begin
        k++;
        @(posedge clk); #1;
        ext_wdata_i = wpat(k);
      end
      if (k < n) begin
        @(negedge clk);
        t++;
      end
    end
    check("wr_beats", 128'(k), 128'(n));
    ext_wvalid_i = 1'b0;
  endtask

  int n, b_iss, b_rv, b_st, b_err, b_g0, b_g1;

  initial begin
    addr_a[0] = '0; addr_a[1] = '0; set_a[0] = '0; set_a[1] = '0; len_a[0] = '0; len_a[1] = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 128'({ext_gnt_o, ext_wready_o, ext_rvalid_o, ext_rid_o, ext_err_o, int_stall_o,
                           mem_req_o, mem_we_o, mem_bank_o, mem_row_o, mem_bank_set_o}), 128'(0));
    check("rst_rdata", 128'(ext_rdata_o), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // port0 read, addr 25, 4 beats: (1,1)..(4,1)
    b_iss = n_issue; b_rv = n_rvalid;
    push_burst(1'b0, 1'b0, 25, 1, 3, n);
    set_req(1'b0, 1'b0, 25, 1, 3);
    wait_gnt(1'b0, "t1_gnt");
    ext_req_i[0] = 1'b0;
    wait_drain("t1_drain");
    check("t1_issues", 128'(n_issue - b_iss), 128'(4));
    check("t1_rvalids", 128'(n_rvalid - b_rv), 128'(4));

    // port1 write, addr 23, 2 beats crossing the row
    b_g1 = n_gnt1;
    do_write(1'b1, 23, 2, 1);
    wait_drain("t2_drain");
    check("t2_wready_after", 128'(ext_wready_o), 128'(0));
    check("t2_gnt_once", 128'(n_gnt1 - b_g1), 128'(1));

    // round-robin ties
    b_g0 = n_gnt0; b_g1 = n_gnt1;
    push_burst(1'b0, 1'b0, 100, 2, 1, n);
    push_burst(1'b1, 1'b0, 200, 0, 2, n);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 100, 2, 1);
    set_req(1'b1, 1'b0, 200, 0, 2);
    wait_gnt(1'b0, "t3_tie_gnt0");
    ext_req_i[0] = 1'b0;
    wait_gnt(1'b1, "t3_then_gnt1");
    ext_req_i[1] = 1'b0;
    wait_drain("t3_drain_a");
    push_burst(1'b0, 1'b0, 300, 1, 0, n);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 300, 1, 0);
    set_req(1'b1, 1'b0, 400, 1, 0);
    wait_gnt(1'b0, "t3_tie2_gnt0");
    ext_req_i = 2'b00;
    wait_drain("t3_drain_b");
    check("t3_gnt0_cnt", 128'(n_gnt0 - b_g0), 128'(2));
    check("t3_gnt1_cnt", 128'(n_gnt1 - b_g1), 128'(1));

    // starvation guard during a 16-beat read
    b_iss = n_issue; b_rv = n_rvalid; b_st = n_stall;
    push_burst(1'b1, 1'b0, 0, 0, 15, n);
    set_req(1'b1, 1'b0, 0, 0, 15);
    wait_gnt(1'b1, "t4_gnt");
    ext_req_i[1] = 1'b0;
    check("t4_c1_req", 128'(mem_req_o), 128'(1));
    check("t4_c1_stall", 128'(int_stall_o), 128'(0));
    @(posedge clk); #1;
    int_req_i = 1'b1;
    for (int c = 2; c <= 18; c++) begin
      @(negedge clk);
      check($sformatf("t4_c%0d_req", c), 128'(mem_req_o), 128'(c != 10 && c <= 17));
      check($sformatf("t4_c%0d_stall", c), 128'(int_stall_o), 128'(c != 10 && c <= 17));
    end
    @(posedge clk); #1;
    int_req_i = 1'b0;
    wait_drain("t4_drain");
    check("t4_issues", 128'(n_issue - b_iss), 128'(16));
    check("t4_rvalids", 128'(n_rvalid - b_rv), 128'(16));
    check("t4_stalls", 128'(n_stall - b_st), 128'(15));

    // internal request blocks grants; then a burst that runs off the top of memory
    b_iss = n_issue; b_err = n_err;
    @(posedge clk); #1;
    int_req_i = 1'b1;
    push_burst(1'b0, 1'b0, NB * BD - 2, 1, 3, n);
    set_req(1'b0, 1'b0, NB * BD - 2, 1, 3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_no_gnt_int", 128'(ext_gnt_o), 128'(0));
    end
    @(posedge clk); #1;
    int_req_i = 1'b0;
    wait_gnt(1'b0, "t5_gnt");
    ext_req_i[0] = 1'b0;
    wait_drain("t5_drain");
    check("t5_issues", 128'(n_issue - b_iss), 128'(2));
    check("t5_err", 128'(n_err - b_err), 128'(exp_err));
    check("t5_err_model", 128'(exp_err), 128'(1));

    // async reset in the third beat of a read
    push_burst(1'b0, 1'b0, 0, 0, 7, n);
    set_req(1'b0, 1'b0, 0, 0, 7);
    wait_gnt(1'b0, "t6_gnt");
    ext_req_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_ctl", 128'({ext_gnt_o, ext_wready_o, ext_rvalid_o, ext_rid_o, ext_err_o, int_stall_o,
                              mem_req_o, mem_we_o, mem_bank_o, mem_row_o, mem_bank_set_o}), 128'(0));
    check("t6_rst_rdata", 128'(ext_rdata_o), 128'(0));
    check("t6_rst_wdata", 128'(mem_wdata_o), 128'(0));
    repeat (2) @(negedge clk);
    iss_q.delete();
    rd_q.delete();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_rvalid", 128'(ext_rvalid_o), 128'(0));
      check("t6_no_req", 128'(mem_req_o), 128'(0));
    end
    push_burst(1'b0, 1'b0, 50, 0, 1, n);
    set_req(1'b0, 1'b0, 50, 0, 1);
    wait_gnt(1'b0, "t6_regnt");
    ext_req_i[0] = 1'b0;
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
